// File: rtl/prio_arb_enc_if.sv
// prio_arb_enc_if -- request/result bus for the priority arbiter encoder.
//   Input side : req (N-bit request vector), mode (0 fixed, 1 round-robin),
//                in_vld / in_rdy handshake.
//   Output side: idx (winning index), hit (any request set),
//                out_vld / out_rdy handshake.
//   slave  : view used by the encoder itself.
//   master : view used by whatever drives requests and consumes results.
interface prio_arb_enc_if #(
  parameter int N = 16,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         mode;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] idx;
  logic         hit;
  logic         out_vld;
  logic         out_rdy;

  modport slave (
    input  req, mode, in_vld, out_rdy,
    output in_rdy, idx, hit, out_vld
  );

  modport master (
    output req, mode, in_vld, out_rdy,
    input  in_rdy, idx, hit, out_vld
  );
endinterface

// File: rtl/prio_arb_enc.sv
// prio_arb_enc -- one-cycle priority / round-robin arbiter and index encoder.
//   clk      : single clock, rising edge.
//   rst      : synchronous, active-high reset.
//   bus      : prio_arb_enc_if.slave
//              req/mode/in_vld in, in_rdy out (= !out_vld | out_rdy),
//              idx/hit/out_vld out, out_rdy in.
//   miss_cnt : (only with PRIO_ARB_ENC_STATS_EN defined) saturating 16-bit
//              count of accepted all-zero request vectors.
// mode 0 picks the highest set bit; mode 1 searches upward from the bit after
// the last round-robin winner, wrapping back to that winner.
// Optional feature macro: PRIO_ARB_ENC_STATS_EN.
module prio_arb_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  prio_arb_enc_if.slave bus
`ifdef PRIO_ARB_ENC_STATS_EN
  ,
  output logic [15:0]  miss_cnt
`endif
);

  logic         accept;
  logic         take;
  logic         any_req;
  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;
  logic [W-1:0] win_idx;

  logic [W-1:0] ptr;
  logic [W-1:0] idx_p1;
  logic         hit_p1;
  logic         vld_p1;

  assign bus.in_rdy = !vld_p1 | bus.out_rdy;
  assign accept     = bus.in_vld & bus.in_rdy;
  assign take       = vld_p1 & bus.out_rdy;

  // ---- stage p0: combinational decode of the presented request vector ----
  always_comb begin
    any_req = |bus.req;

    // Later (higher) set bits overwrite earlier ones, leaving the highest.
    fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) fp_idx = W'(i);
    end

    // Offsets 1..N from ptr: offset N lands on ptr itself, so a lone request
    // on the last winner is still granted.
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found && bus.req[(int'(ptr) + k) % N]) begin
        rr_found = 1'b1;
        rr_idx   = W'((int'(ptr) + k) % N);
      end
    end

    // Both searches yield 0 when req is empty, giving the idx = 0 miss result.
    win_idx = bus.mode ? rr_idx : fp_idx;
  end

  // ---- stage p1: single output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
      idx_p1 <= '0;
      ptr    <= W'(N - 1);
    end else if (accept) begin
      vld_p1 <= 1'b1;
      hit_p1 <= any_req;
      idx_p1 <= win_idx;
      if (bus.mode && any_req) ptr <= win_idx;
    end else if (take) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.idx     = idx_p1;
  assign bus.hit     = hit_p1;
  assign bus.out_vld = vld_p1;

`ifdef PRIO_ARB_ENC_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (accept && !any_req) begin
      miss_cnt <= sat_inc16(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_prio_arb_enc.sv
module tb_prio_arb_enc;
  localparam int N = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_arb_enc_if #(.N(N)) bus ();

`ifdef PRIO_ARB_ENC_STATS_EN
  logic [15:0] miss_cnt;
`endif

  prio_arb_enc #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PRIO_ARB_ENC_STATS_EN
    ,
    .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    logic         mode;
    logic [N-1:0] req;
    logic [W-1:0] exp_idx;
    logic         exp_hit;
  } vec_t;

  vec_t vecs[21];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_miss = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_miss(input string name);
`ifdef PRIO_ARB_ENC_STATS_EN
    check(name, 64'(miss_cnt), 64'(exp_miss));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_miss = 0;
  endtask

  initial begin
    // mode, req, expected idx, expected hit (pointer state in trailing comment)
    vecs[0]  = '{1'b0, 16'h0A10, 4'd11, 1'b1}; // ptr 15
    vecs[1]  = '{1'b0, 16'h0001, 4'd0,  1'b1};
    vecs[2]  = '{1'b0, 16'h8000, 4'd15, 1'b1};
    vecs[3]  = '{1'b0, 16'hFFFF, 4'd15, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 4'd0,  1'b0}; // miss 0 -> 1
    vecs[5]  = '{1'b1, 16'h8001, 4'd0,  1'b1}; // ptr 0
    vecs[6]  = '{1'b1, 16'h8001, 4'd15, 1'b1}; // ptr 15
    vecs[7]  = '{1'b1, 16'h8001, 4'd0,  1'b1}; // ptr 0
    vecs[8]  = '{1'b1, 16'h0060, 4'd5,  1'b1}; // ptr 5
    vecs[9]  = '{1'b1, 16'h0000, 4'd0,  1'b0}; // ptr stays 5
    vecs[10] = '{1'b1, 16'h0021, 4'd0,  1'b1}; // ptr 0
    vecs[11] = '{1'b1, 16'h0020, 4'd5,  1'b1}; // ptr 5
    vecs[12] = '{1'b0, 16'h0001, 4'd0,  1'b1}; // ptr stays 5
    vecs[13] = '{1'b1, 16'h0021, 4'd0,  1'b1}; // ptr 0
    vecs[14] = '{1'b1, 16'h0020, 4'd5,  1'b1}; // ptr 5
    vecs[15] = '{1'b1, 16'h0020, 4'd5,  1'b1}; // wrap to last winner
    vecs[16] = '{1'b1, 16'h0021, 4'd0,  1'b1}; // ptr 0
    vecs[17] = '{1'b1, 16'h0003, 4'd1,  1'b1}; // ptr 1
    vecs[18] = '{1'b1, 16'hFFFF, 4'd2,  1'b1}; // ptr 2
    vecs[19] = '{1'b0, 16'h0300, 4'd9,  1'b1}; // ptr stays 2
    vecs[20] = '{1'b1, 16'h0004, 4'd2,  1'b1}; // only bit ptr set

    rst         = 1'b1;
    bus.req     = '0;
    bus.mode    = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    do_reset();

    // Reset state and ready in the first cycle after release.
    check("reset_out_vld", 64'(bus.out_vld), 64'd0);
    check("reset_idx", 64'(bus.idx), 64'd0);
    check("reset_hit", 64'(bus.hit), 64'd0);
    check("reset_in_rdy", 64'(bus.in_rdy), 64'd1);
    check_miss("reset_miss_cnt");

    // Back-to-back accepts with out_rdy held high.
    for (int v = 0; v < 21; v++) begin
      bus.mode   = vecs[v].mode;
      bus.req    = vecs[v].req;
      bus.in_vld = 1'b1;
      if (vecs[v].req == '0) exp_miss++;
      @(negedge clk);
      check($sformatf("vec%0d_out_vld", v), 64'(bus.out_vld), 64'd1);
      check($sformatf("vec%0d_idx", v), 64'(bus.idx), 64'(vecs[v].exp_idx));
      check($sformatf("vec%0d_hit", v), 64'(bus.hit), 64'(vecs[v].exp_hit));
      check_miss($sformatf("vec%0d_miss_cnt", v));
    end

    // Take without accept clears out_vld; idle inputs are ignored.
    bus.in_vld = 1'b0;
    bus.req    = 16'hFFFF;
    @(negedge clk);
    check("drain_out_vld", 64'(bus.out_vld), 64'd0);
    @(negedge clk);
    check("idle_out_vld", 64'(bus.out_vld), 64'd0);
    check("idle_in_rdy", 64'(bus.in_rdy), 64'd1);

    // Back-pressure: result held for three cycles, then take + accept together.
    bus.mode    = 1'b0;
    bus.req     = 16'h0010;
    bus.in_vld  = 1'b1;
    bus.out_rdy = 1'b0;
    @(negedge clk);
    bus.req = 16'h0800;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d_in_rdy", c), 64'(bus.in_rdy), 64'd0);
      check($sformatf("stall%0d_out_vld", c), 64'(bus.out_vld), 64'd1);
      check($sformatf("stall%0d_idx", c), 64'(bus.idx), 64'd4);
      check($sformatf("stall%0d_hit", c), 64'(bus.hit), 64'd1);
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    #1;
    check("release_in_rdy", 64'(bus.in_rdy), 64'd1);
    @(negedge clk);
    check("take_accept_out_vld", 64'(bus.out_vld), 64'd1);
    check("take_accept_idx", 64'(bus.idx), 64'd11);
    bus.in_vld = 1'b0;
    @(negedge clk);
    check("take_only_out_vld", 64'(bus.out_vld), 64'd0);

    // Reset wins over pending result, accept and take; pointer returns to 15.
    bus.mode    = 1'b1;
    bus.req     = 16'h0000;
    bus.in_vld  = 1'b1;
    bus.out_rdy = 1'b0;
    @(negedge clk); // miss accepted, result stalled; ptr currently 2
    check("pre_rst_out_vld", 64'(bus.out_vld), 64'd1);
    rst         = 1'b1;
    bus.out_rdy = 1'b1;
    bus.req     = 16'h8001;
    @(negedge clk);
    check("rst_prio_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_prio_idx", 64'(bus.idx), 64'd0);
    check("rst_prio_hit", 64'(bus.hit), 64'd0);
    exp_miss = 0;
    check_miss("rst_prio_miss_cnt");
    rst        = 1'b0;
    bus.in_vld = 1'b0;
    #1;
    check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    bus.in_vld = 1'b1;
    @(negedge clk);
    check("post_rst_rr_idx", 64'(bus.idx), 64'd0); // ptr 15 -> search from 0
    @(negedge clk);
    check("post_rst_rr_idx2", 64'(bus.idx), 64'd15);
    bus.in_vld = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_arb_enc.md
PRIO_ARB_ENC -- requirements
Module: prio_arb_enc

Interface
REQ-001 SHALL have parameter N, default 16, meaning request vector width (2..64).
REQ-002 SHALL have parameter W, default $clog2(N), meaning index width; derived and not overridden.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous, active-high.
REQ-005 SHALL have port req  input  N  meaning request vector; bit i is candidate i.
REQ-006 SHALL have port mode  input  1  meaning 0 = fixed priority, 1 = round-robin; sampled with req.
REQ-007 SHALL have port in_vld  input  1  meaning req/mode are valid this cycle.
REQ-008 SHALL have port in_rdy  output  1  meaning the block can accept req/mode this cycle.
REQ-009 SHALL have port idx  output  W  meaning encoded index of the winning request.
REQ-010 SHALL have port hit  output  1  meaning at least one req bit was set.
REQ-011 SHALL have port out_vld  output  1  meaning idx/hit hold a valid result.
REQ-012 SHALL have port out_rdy  input  1  meaning the consumer takes the result this cycle.

Function
REQ-013 SHALL define accept as in_vld & in_rdy at a rising edge, and take as out_vld & out_rdy at a rising edge.
REQ-014 SHALL drive in_rdy = !out_vld | out_rdy (single output register, combinational ready, no skid).
REQ-015 SHALL on accept register idx, hit and set out_vld = 1 the next cycle; latency exactly 1 cycle.
REQ-016 SHALL on take without accept clear out_vld; take and accept in the same cycle leaves out_vld = 1 with the new result.
REQ-017 SHALL hold idx, hit, out_vld stable while out_vld & !out_rdy.
REQ-018 SHALL in mode 0 select the highest set index of req (bit N-1 highest priority).
REQ-019 SHALL in mode 1 search ascending from ptr+1 modulo N, wrapping through 0 to ptr, selecting the first set bit.
REQ-020 SHALL keep a W-bit pointer ptr, updated to the winning idx on accept only when mode = 1 and hit = 1.
REQ-021 SHALL leave ptr unchanged on mode-0 accepts and on accepts with req = 0.
REQ-022 SHALL for req = 0 produce hit = 0, idx = 0, out_vld = 1 (a valid "no request" result).
REQ-023 SHALL in mode 1 with only bit ptr set select ptr again (wrap-around to the last winner).
REQ-024 SHALL ignore req and mode in cycles with no accept.
REQ-025 SHALL decode purely from the sampled req, with no dependence on previous req values other than through ptr.

Reset
REQ-026 SHALL with rst = 1 at a rising edge set out_vld = 0, hit = 0, idx = 0, ptr = N-1 (first round-robin search starts at 0).
REQ-027 SHALL give rst priority over accept and take in the same cycle; a result pending mid-operation is discarded.
REQ-028 SHALL drive in_rdy = 1 in the first cycle after reset is released.

Configuration
REQ-029 SHALL with macro PRIO_ARB_ENC_STATS_EN defined add output miss_cnt (16 bits), incremented on every accept with req = 0, saturating at 16'hFFFF, reset to 0 by rst.
REQ-030 SHALL without PRIO_ARB_ENC_STATS_EN omit miss_cnt and its counter entirely; all other behaviour identical.

Verification (N = 16)
REQ-031 SHALL cover: mode 0, req = 16'h0A10, in_vld = 1, out_rdy = 1 -> next cycle out_vld = 1, hit = 1, idx = 11.
REQ-032 SHALL cover: after reset, mode 1, req = 16'h8001 accepted three times -> idx 0, 15, 0; ptr ends at 0.
REQ-033 SHALL cover: req = 16'h0000 accepted -> hit = 0, idx = 0, out_vld = 1, ptr unchanged; with PRIO_ARB_ENC_STATS_EN miss_cnt goes 0 -> 1.
REQ-034 SHALL cover: out_vld = 1 with out_rdy = 0 for 3 cycles while in_vld = 1 -> in_rdy = 0, idx/hit stable; out_rdy = 1 -> take and new accept in the same cycle.
REQ-035 SHALL cover: mode 1, ptr = 5, req = 16'h0020 -> idx = 5 (wrap to last winner); then req = 16'h0021 -> idx = 0.
REQ-036 SHALL cover: rst = 1 asserted with out_vld = 1 and in_vld = 1 -> next cycle out_vld = 0, idx = 0, ptr = 15, miss_cnt = 0.
